imem_loader: RTL

//  Boot-time program loader upstream of the instruction fetch unit. Accepts a byte

---
 rtl/imem_loader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot-time program loader: receives a length-prefixed byte stream, packs the bytes
// little-endian into 32-bit words and writes them to instruction memory, then releases the CPU.
module imem_loader #(
  parameter int IMEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        reload,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_run,
  output logic        busy,
  output logic        err
);

  localparam int          MAX_WORDS = IMEM_BYTES / 4;
  localparam logic [15:0] MAX_LEN   = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    ST_LEN0 = 3'd0,
    ST_LEN1 = 3'd1,
    ST_LOAD = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [23:0] pack_q, pack_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        xfer_s;
  logic        last_wr_s;
  logic        s_ready_s;
  logic [15:0] len_new_s;

  // Final word is being written: stop accepting bytes so no trailing byte is swallowed.
  assign last_wr_s = we_q && (word_cnt_q == len_q);
  assign len_new_s = {s_data, len_q[7:0]};
  assign xfer_s    = s_valid && s_ready_s;

  // Stream-ready decode from the current state.
  always_comb begin
    s_ready_s = 1'b0;
    case (state_q)
      ST_LEN0: s_ready_s = 1'b1;
      ST_LEN1: s_ready_s = 1'b1;
      ST_LOAD: s_ready_s = !last_wr_s;
      default: s_ready_s = 1'b0;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    pack_d     = pack_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      ST_LEN0: begin
        if (xfer_s) begin
          len_d[7:0] = s_data;
          state_d    = ST_LEN1;
        end else begin
          state_d = ST_LEN0;
        end
      end
      ST_LEN1: begin
        if (xfer_s) begin
          len_d = len_new_s;
          if (len_new_s == 16'd0) begin
            state_d = ST_RUN;
          end else if (len_new_s > MAX_LEN) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LEN1;
        end
      end
      ST_LOAD: begin
        if (last_wr_s) begin
          state_d = ST_RUN;
        end else if (xfer_s) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: pack_d[7:0]   = s_data;
            2'd1: pack_d[15:8]  = s_data;
            2'd2: pack_d[23:16] = s_data;
            default: begin
              we_d       = 1'b1;
              wdata_d    = {s_data, pack_q};
              addr_d     = {14'd0, word_cnt_q, 2'b00};
              word_cnt_d = word_cnt_q + 16'd1;
            end
          endcase
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN, ST_ERR: begin
        if (reload) begin
          state_d    = ST_LEN0;
          len_d      = 16'd0;
          byte_cnt_d = 2'd0;
          word_cnt_d = 16'd0;
          pack_d     = 24'd0;
          addr_d     = 32'd0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_LEN0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LEN0;
      len_q      <= 16'd0;
      byte_cnt_q <= 2'd0;
      word_cnt_q <= 16'd0;
      pack_q     <= 24'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      pack_q     <= pack_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign s_ready    = s_ready_s;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_run    = (state_q == ST_RUN);
  assign busy       = (state_q == ST_LEN0) || (state_q == ST_LEN1) || (state_q == ST_LOAD);
  assign err        = (state_q == ST_ERR);

endmodule
